// File: rtl/lsu_pkg.sv
// Purpose: shared types, RISC-V funct3 encodings and byte-strobe helper for the LSU.
// Latency: n/a (types and combinational function only).
// Backpressure: n/a.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_UNMAPPED = 2'd2,
    FC_TIMEOUT  = 2'd3
  } fault_cause_e;

  // Loads
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  // Stores
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  // Byte strobes for a 2^size_log2 byte access at byte offset 'offset' of a
  // lane of up to 8 bytes; callers keep only the low DATA_WIDTH/8 bits.
  function automatic logic [7:0] gen_wstrb(input logic [1:0] size_log2,
                                           input logic [2:0] offset);
    logic [7:0] base;
    case (size_log2)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Purpose: extract the addressed byte/half/word/double from a bus word and sign/zero extend it.
// Latency: combinational.
// Backpressure: none.
// Ports: raw_data (bus word), offset (byte offset in word), funct3 (size/sign), load_data (result).
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]            raw_data,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]  offset,
  input  logic [2:0]                       funct3,
  output logic [DATA_WIDTH-1:0]            load_data
);

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted   = raw_data >> {offset, 3'b000};
    load_data = shifted;
    case (funct3[1:0])
      LB[1:0]: begin
        if (funct3[2]) load_data = DATA_WIDTH'(shifted[7:0]);
        else           load_data = DATA_WIDTH'($signed(shifted[7:0]));
      end
      LH[1:0]: begin
        if (funct3[2]) load_data = DATA_WIDTH'(shifted[15:0]);
        else           load_data = DATA_WIDTH'($signed(shifted[15:0]));
      end
      LW[1:0]: begin
        if (funct3[2]) load_data = DATA_WIDTH'(shifted[31:0]);
        else           load_data = DATA_WIDTH'($signed(shifted[31:0]));
      end
      default: load_data = shifted;  // double: only reachable at 64-bit
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Purpose: memory-stage load/store unit; decodes NUM_SLAVES regions, req/ack bus, fault reporting.
// Latency: zero-wait access completes (rsp_valid) 2 cycles after acceptance; faults after 1 cycle.
// Backpressure: stall holds the pipeline while a request is accepted or the bus waits for s_ack.
// Ports: clk/reset; req_* from the memory stage; stall/rsp_*/fault* back to pipeline and csr;
//        s_* request/ack bus to the slaves (s_ack[i] and s_rdata[i*DATA_WIDTH +: DATA_WIDTH] per slave).
// Option: define LSU_TIMEOUT_EN to abort BUS after TIMEOUT_CYCLES without ack (fault cause 3).
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 2,
  // Region tables are listed slave 0 first, i.e. slave 0 occupies the top slice.
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h0000_0000, 32'h8000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_FF00},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  input  logic                             req_we,
  input  logic [2:0]                       req_funct3,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             stall,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             fault,
  output logic [1:0]                       fault_cause,
  output logic [ADDR_WIDTH-1:0]            fault_addr,
  output logic                             s_req,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic                             s_we,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  output logic [DATA_WIDTH/8-1:0]          s_wstrb,
  input  logic [NUM_SLAVES-1:0]            s_ack,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  lsu_state_e            state_q, state_d;
  logic                  s_req_q, s_req_d;
  logic [NUM_SLAVES-1:0] s_sel_q, s_sel_d;
  logic                  s_we_q, s_we_d;
  logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
  logic [NB-1:0]         s_wstrb_q, s_wstrb_d;
  logic [IDX_W-1:0]      sel_idx_q, sel_idx_d;
  logic [2:0]            funct3_q, funct3_d;
  fault_cause_e          cause_q, cause_d;
  logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  // Request decode (only meaningful in IDLE).
  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic [3:0]            size_b;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [7:0]            wstrb_full;
  int                    lane;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    // Scan downwards so the lowest matching index is the one left standing.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((req_addr & SLAVE_MASK[(NUM_SLAVES-1-i)*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[(NUM_SLAVES-1-i)*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    size_b     = 4'd1 << req_funct3[1:0];
    misaligned = (size_b > 4'(NB)) || ((req_addr[2:0] & 3'(size_b - 4'd1)) != 3'd0);
    // Each byte lane takes the store byte whose index matches it modulo the access size.
    wdata_rep  = '0;
    lane       = 0;
    for (int i = 0; i < NB; i++) begin
      lane = i & (int'(size_b) - 1);
      wdata_rep[i*8 +: 8] = req_wdata[lane*8 +: 8];
    end
    wstrb_full = gen_wstrb(req_funct3[1:0], 3'(req_addr[OFF_W-1:0]));
  end

  logic                  ack_sel;
  logic [DATA_WIDTH-1:0] load_data;

  assign ack_sel = s_ack[sel_idx_q];

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .raw_data  (s_rdata[sel_idx_q*DATA_WIDTH +: DATA_WIDTH]),
    .offset    (s_addr_q[OFF_W-1:0]),
    .funct3    (funct3_q),
    .load_data (load_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out;
  assign timed_out = (cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d      = state_q;
    s_req_d      = s_req_q;
    s_sel_d      = s_sel_q;
    s_we_d       = s_we_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_wstrb_d    = s_wstrb_q;
    sel_idx_d    = sel_idx_q;
    funct3_d     = funct3_q;
    cause_d      = cause_q;
    fault_addr_d = fault_addr_q;
    rsp_rdata_d  = rsp_rdata_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rsp_rdata_d = '0;
          if (misaligned || !hit) begin
            state_d      = RESP;
            cause_d      = misaligned ? FC_MISALIGN : FC_UNMAPPED;
            fault_addr_d = req_addr;
          end else begin
            state_d   = BUS;
            cause_d   = FC_NONE;
            s_req_d   = 1'b1;
            s_sel_d   = NUM_SLAVES'(1) << hit_idx;
            s_we_d    = req_we;
            s_addr_d  = req_addr;
            s_wdata_d = wdata_rep;
            s_wstrb_d = wstrb_full[NB-1:0];
            sel_idx_d = hit_idx;
            funct3_d  = req_funct3;
`ifdef LSU_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end
        end
      end
      BUS: begin
        if (ack_sel) begin
          state_d     = RESP;
          s_req_d     = 1'b0;
          s_sel_d     = '0;
          s_we_d      = 1'b0;
          s_wstrb_d   = '0;
          rsp_rdata_d = s_we_q ? '0 : load_data;
        end
`ifdef LSU_TIMEOUT_EN
        else if (timed_out) begin
          state_d      = RESP;
          s_req_d      = 1'b0;
          s_sel_d      = '0;
          s_we_d       = 1'b0;
          s_wstrb_d    = '0;
          cause_d      = FC_TIMEOUT;
          fault_addr_d = s_addr_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;  // RESP: any req_valid here belongs to the retiring instruction
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      s_req_q      <= 1'b0;
      s_sel_q      <= '0;
      s_we_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_wstrb_q    <= '0;
      sel_idx_q    <= '0;
      funct3_q     <= '0;
      cause_q      <= FC_NONE;
      fault_addr_q <= '0;
      rsp_rdata_q  <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      s_req_q      <= s_req_d;
      s_sel_q      <= s_sel_d;
      s_we_q       <= s_we_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      s_wstrb_q    <= s_wstrb_d;
      sel_idx_q    <= sel_idx_d;
      funct3_q     <= funct3_d;
      cause_q      <= cause_d;
      fault_addr_q <= fault_addr_d;
      rsp_rdata_q  <= rsp_rdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign stall       = ((state_q == IDLE) && req_valid) || (state_q == BUS);
  assign rsp_valid   = (state_q == RESP);
  assign fault       = rsp_valid && (cause_q != FC_NONE);
  assign fault_cause = rsp_valid ? cause_q : FC_NONE;
  assign fault_addr  = fault_addr_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign s_req       = s_req_q;
  assign s_sel       = s_sel_q;
  assign s_we        = s_we_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_wstrb     = s_wstrb_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Purpose: directed self-checking bench for lsu_bus_ctrl (32-bit data, two slaves, TIMEOUT_CYCLES=4).
// Latency: inputs driven just after the falling edge, outputs sampled 1 time unit later.
// Backpressure: the bench models the pipeline holding req_valid while stall is high.
module tb_lsu_bus_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, fault, s_req, s_we;
  logic [31:0] rsp_rdata, fault_addr, s_addr, s_wdata;
  logic [1:0]  fault_cause, s_sel, s_ack;
  logic [3:0]  s_wstrb;
  logic [63:0] s_rdata;

  int errors = 0;
  int checks = 0;

  // Observations from the last run_access call.
  bit          o_got;
  int          o_rspcyc, o_stall, o_reqc;
  logic        o_stall_resp, o_fault, o_we;
  logic [1:0]  o_cause, o_sel;
  logic [3:0]  o_strb;
  logic [31:0] o_rdata, o_faddr, o_wdata;

  lsu_bus_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SLAVES(2),
    .SLAVE_BASE({32'h0000_0000, 32'h8000_0000}),
    .SLAVE_MASK({32'hFFFF_0000, 32'hFFFF_FF00}),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
    .fault_cause(fault_cause), .fault_addr(fault_addr), .s_req(s_req), .s_sel(s_sel),
    .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  // Called at a falling edge; returns at a falling edge (the cycle after RESP,
  // or after 'budget' cycles without a response). Slave 'ack_slave' acks in
  // its BUS cycle number 'ack_wait' (never if negative); with 'noise' the other
  // slave acks in the preceding BUS cycles.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int ack_slave, input int ack_wait,
                            input bit noise, input int budget);
    int bus_cyc = 0;
    o_got = 0; o_rspcyc = -1; o_stall = 0; o_reqc = 0; o_stall_resp = 1'bx;
    o_fault = 1'bx; o_cause = 2'bxx; o_rdata = 'x; o_faddr = 'x;
    o_sel = '0; o_strb = '0; o_wdata = '0; o_we = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    s_ack = 2'b00;
    for (int cyc = 0; cyc < budget; cyc++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        o_got = 1; o_rspcyc = cyc; o_rdata = rsp_rdata; o_fault = fault;
        o_cause = fault_cause; o_faddr = fault_addr; o_stall_resp = stall;
        req_valid = 1'b0; s_ack = 2'b00;
        @(negedge clk);
        break;
      end
      if (stall === 1'b1) o_stall++;
      if (s_req === 1'b1) begin
        if (o_reqc == 0) begin
          o_sel = s_sel; o_strb = s_wstrb; o_wdata = s_wdata; o_we = s_we;
        end
        o_reqc++;
        if (ack_wait >= 0 && bus_cyc == ack_wait) s_ack = (ack_slave == 0) ? 2'b01 : 2'b10;
        else if (noise)                           s_ack = (ack_slave == 0) ? 2'b10 : 2'b01;
        else                                      s_ack = 2'b00;
        bus_cyc++;
      end else begin
        s_ack = 2'b00;
      end
      @(negedge clk);
    end
    req_valid = 1'b0; s_ack = 2'b00;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; s_ack = 2'b00; s_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({stall, rsp_valid, fault, s_req, s_we} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {stall, rsp_valid, fault, s_req, s_we}); end
    checks++; if ({s_sel, s_wstrb, fault_cause} !== 8'h00) begin errors++;
      $display("FAIL reset_sel_strb_cause: got %h required 00", {s_sel, s_wstrb, fault_cause}); end
    checks++; if ({rsp_rdata, fault_addr, s_addr, s_wdata} !== 128'h0) begin errors++;
      $display("FAIL reset_data: got %h required 0", {rsp_rdata, fault_addr, s_addr, s_wdata}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw_basic;
    s_rdata = {32'h5555_5555, 32'hDEAD_BEEF};
    run_access(1'b0, LW, 32'h0000_0010, '0, 0, 0, 1'b0, 20);
    checks++; if (o_rspcyc !== 2) begin errors++; $display("FAIL lw_rsp_cycle: got %0d required 2", o_rspcyc); end
    checks++; if (o_stall !== 2) begin errors++; $display("FAIL lw_stall_cycles: got %0d required 2", o_stall); end
    checks++; if (o_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata: got %h required deadbeef", o_rdata); end
    checks++; if ({o_sel, o_we, o_fault, o_stall_resp} !== 5'b01000) begin errors++;
      $display("FAIL lw_sel_we_fault_stall: got %b required 01000", {o_sel, o_we, o_fault, o_stall_resp}); end
    #1;
    checks++; if ({rsp_valid, s_req} !== 2'b00) begin errors++; $display("FAIL lw_idle_after: got %b required 00", {rsp_valid, s_req}); end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s  [4] = '{LB, LBU, LH, LHU};
    logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
    s_rdata = {32'h5555_5555, 32'h80FF_FFFF};
    for (int i = 0; i < 4; i++) begin
      run_access(1'b0, f3s[i], adrs[i], '0, 0, 0, 1'b0, 20);
      checks++; if (o_rdata !== exps[i]) begin errors++;
        $display("FAIL load_ext[%0d]: got %h required %h", i, o_rdata, exps[i]); end
    end
  endtask

  task automatic test_uart_load;
    s_rdata = {32'hCAFE_F00D, 32'h1111_1111};
    run_access(1'b0, LW, 32'h8000_0004, '0, 1, 0, 1'b0, 20);
    checks++; if (o_sel !== 2'b10) begin errors++; $display("FAIL uart_load_sel: got %b required 10", o_sel); end
    checks++; if (o_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL uart_load_rdata: got %h required cafef00d", o_rdata); end
  endtask

  task automatic test_store_sh;
    s_rdata = {32'h7777_7777, 32'h6666_6666};
    run_access(1'b1, SH, 32'h8000_0002, 32'h1234_ABCD, 1, 3, 1'b0, 20);
    checks++; if ({o_sel, o_strb, o_we} !== 7'b10_1100_1) begin errors++;
      $display("FAIL sh_sel_strb_we: got %b required 1011001", {o_sel, o_strb, o_we}); end
    checks++; if (o_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h required abcdabcd", o_wdata); end
    checks++; if (o_stall !== 5 || o_rspcyc !== 5 || o_reqc !== 4) begin errors++;
      $display("FAIL sh_timing: got stall=%0d rsp=%0d req=%0d required 5 5 4", o_stall, o_rspcyc, o_reqc); end
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL sh_rdata: got %h required 0", o_rdata); end
  endtask

  task automatic test_store_misc;
    run_access(1'b1, SB, 32'h0000_0005, 32'hFFFF_FFA5, 0, 0, 1'b0, 20);
    checks++; if ({o_sel, o_strb} !== 6'b01_0010 || o_wdata !== 32'hA5A5_A5A5) begin errors++;
      $display("FAIL sb_lanes: got sel=%b strb=%b wdata=%h required 01 0010 a5a5a5a5", o_sel, o_strb, o_wdata); end
    run_access(1'b1, SW, 32'h0000_0008, 32'h0102_0304, 0, 0, 1'b0, 20);
    checks++; if (o_strb !== 4'b1111 || o_wdata !== 32'h0102_0304) begin errors++;
      $display("FAIL sw_lanes: got strb=%b wdata=%h required 1111 01020304", o_strb, o_wdata); end
  endtask

  task automatic test_faults;
    logic [2:0]  f3s  [4] = '{LW, LW, LH, LD};
    logic [31:0] adrs [4] = '{32'h0000_0002, 32'h4000_0000, 32'h4000_0001, 32'h0000_0008};
    logic [1:0]  exps [4] = '{2'd1, 2'd2, 2'd1, 2'd1};
    for (int i = 0; i < 4; i++) begin
      run_access(1'b0, f3s[i], adrs[i], '0, 0, 0, 1'b0, 20);
      checks++; if (o_rspcyc !== 1 || o_reqc !== 0 || o_fault !== 1'b1) begin errors++;
        $display("FAIL fault[%0d]_timing: got rsp=%0d req=%0d fault=%b required 1 0 1", i, o_rspcyc, o_reqc, o_fault); end
      checks++; if (o_cause !== exps[i] || o_faddr !== adrs[i]) begin errors++;
        $display("FAIL fault[%0d]_info: got cause=%0d addr=%h required %0d %h", i, o_cause, o_faddr, exps[i], adrs[i]); end
    end
    s_rdata = {32'h0, 32'h0000_00AA};
    run_access(1'b0, LW, 32'h0000_0020, '0, 0, 0, 1'b0, 20);
    checks++; if (o_fault !== 1'b0 || o_cause !== 2'd0 || o_faddr !== 32'h0000_0008) begin errors++;
      $display("FAIL fault_addr_hold: got fault=%b cause=%0d addr=%h required 0 0 00000008", o_fault, o_cause, o_faddr); end
  endtask

  task automatic test_ack_ignore;
    s_rdata = {32'hFFFF_0000, 32'h0BAD_F00D};
    run_access(1'b0, LW, 32'h0000_0020, '0, 0, 2, 1'b1, 20);
    checks++; if (o_rspcyc !== 4 || o_rdata !== 32'h0BAD_F00D) begin errors++;
      $display("FAIL ack_ignore: got rsp=%0d rdata=%h required 4 0badf00d", o_rspcyc, o_rdata); end
  endtask

  task automatic test_resp_ignore;
    s_rdata = {32'h0, 32'h1234_5678};
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'h10;
    @(negedge clk); s_ack = 2'b01;
    @(negedge clk); s_ack = 2'b00; #1;
    checks++; if ({rsp_valid, stall} !== 2'b10 || rsp_rdata !== 32'h1234_5678) begin errors++;
      $display("FAIL resp_cycle: got valid/stall=%b rdata=%h required 10 12345678", {rsp_valid, stall}, rsp_rdata); end
    @(negedge clk); req_valid = 1'b0; #1;
    checks++; if ({stall, s_req, rsp_valid} !== 3'b000) begin errors++;
      $display("FAIL resp_req_ignored: got %b required 000", {stall, s_req, rsp_valid}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    s_rdata = {32'h0, 32'hA0A0_A0A0};
    run_access(1'b0, LW, 32'h0000_0030, '0, 0, 0, 1'b0, 20);
    s_rdata = {32'h0, 32'h0B0B_0B0B};
    run_access(1'b0, LBU, 32'h0000_0031, '0, 0, 0, 1'b0, 20);
    checks++; if (o_rspcyc !== 2 || o_rdata !== 32'h0000_000B) begin errors++;
      $display("FAIL back_to_back: got rsp=%0d rdata=%h required 2 0000000b", o_rspcyc, o_rdata); end
  endtask

  task automatic test_timeout;
`ifdef LSU_TIMEOUT_EN
    run_access(1'b0, LW, 32'h0000_0040, '0, 0, -1, 1'b0, 20);
    checks++; if (o_reqc !== 4 || o_rspcyc !== 5) begin errors++;
      $display("FAIL timeout_timing: got req=%0d rsp=%0d required 4 5", o_reqc, o_rspcyc); end
    checks++; if (o_fault !== 1'b1 || o_cause !== 2'd3 || o_faddr !== 32'h40) begin errors++;
      $display("FAIL timeout_info: got fault=%b cause=%0d addr=%h required 1 3 00000040", o_fault, o_cause, o_faddr); end
`else
    run_access(1'b0, LW, 32'h0000_0040, '0, 0, -1, 1'b0, 12);
    checks++; if (o_got !== 1'b0 || o_stall !== 12 || o_reqc !== 11) begin errors++;
      $display("FAIL no_timeout_wait: got rsp=%b stall=%0d req=%0d required 0 12 11", o_got, o_stall, o_reqc); end
    reset = 1'b1; @(negedge clk); reset = 1'b0; #1;
    checks++; if ({s_req, stall} !== 2'b00) begin errors++;
      $display("FAIL no_timeout_recover: got %b required 00", {s_req, stall}); end
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    s_rdata = {32'h0, 32'hFEED_FACE};
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'h10;
    @(negedge clk);               // first BUS cycle
    @(negedge clk);               // second BUS cycle
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if ({s_req, rsp_valid, stall} !== 3'b000) begin errors++;
      $display("FAIL reset_mid: got req/valid/stall=%b required 000", {s_req, rsp_valid, stall}); end
    reset = 1'b0;
    @(negedge clk); s_ack = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); s_ack = 2'b00; #1;
      if (rsp_valid !== 1'b0 || s_req !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_late_ack: got %0d bad cycles required 0", bad); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_load_ext();
    test_uart_load();
    test_store_sh();
    test_store_misc();
    test_faults();
    test_ack_ignore();
    test_resp_ignore();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Parametrised load/store unit for the memory stage of the pipelined core. It generalises the fixed dmem/uart address decode to NUM_SLAVES memory-mapped regions with a req/ack handshake, so slaves may have variable latency. It generates byte/half/word (and double at 64-bit) strobes and load sign/zero extension. It stalls the pipeline until each access completes and reports misaligned, unmapped and timeout faults to the csr block.

Parameters:
DATA_WIDTH, 32, data bus width; legal values 32 or 64.
ADDR_WIDTH, 32, address width.
NUM_SLAVES, 2, number of decoded regions; index 0 is dmem, index 1 is uart.
SLAVE_BASE, {32'h0000_0000, 32'h8000_0000}, packed NUM_SLAVES*ADDR_WIDTH region bases.
SLAVE_MASK, {32'hFFFF_0000, 32'hFFFF_FF00}, packed region masks; a slave is hit when (addr & mask) == base.
TIMEOUT_CYCLES, 255, maximum BUS-state cycles without ack.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  memory-stage load/store present
req_we  in  1  1=store, 0=load
req_funct3  in  3  RISC-V size/sign field
req_addr  in  ADDR_WIDTH  effective address (ALU result)
req_wdata  in  DATA_WIDTH  store data (rs2)
stall  out  1  hold PC and pipeline registers
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  aligned, extended load data
fault  out  1  valid with rsp_valid; access failed
fault_cause  out  2  0 none, 1 misaligned, 2 unmapped, 3 timeout
fault_addr  out  ADDR_WIDTH  faulting address
s_req  out  1  bus request
s_sel  out  NUM_SLAVES  one-hot slave select
s_we  out  1  write
s_addr  out  ADDR_WIDTH  request address
s_wdata  out  DATA_WIDTH  lane-replicated store data
s_wstrb  out  DATA_WIDTH/8  byte strobes
s_ack  in  NUM_SLAVES  per-slave completion
s_rdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data

Behaviour:
- Reset: state IDLE. stall, rsp_valid, fault, s_req and s_we are 0. s_sel and s_wstrb are 0. rsp_rdata, fault_addr, s_addr and s_wdata are 0. fault_cause is 0.
- FSM IDLE -> BUS -> RESP -> IDLE; also IDLE -> RESP directly on a fault.
- IDLE with req_valid: register the address, data, funct3 and we, and decode.
  - Size = 1<<funct3[1:0]. A size wider than DATA_WIDTH/8, or addr not a multiple of size, gives cause 1.
  - No region hit gives cause 2. Cause 1 has priority over cause 2.
  - On a fault, go to RESP with no bus activity.
  - Multiple region hits: the lowest index wins.
- BUS: s_req, s_sel, s_we, s_addr, s_wdata and s_wstrb are registered and held stable until s_ack[sel]. Acks from unselected slaves are ignored.
  - An ack in the first BUS cycle is legal.
  - On ack: capture s_rdata[sel] and deassert s_req on the next edge; go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - fault and fault_cause are valid here only. fault_addr holds its value until the next fault.
- stall = (state==IDLE && req_valid) || state==BUS. stall is 0 in RESP, so the instruction advances with rsp_rdata.
- Latency:
  - Good access, zero-wait slave: accepted in cycle 0, BUS in cycle 1, rsp_valid in cycle 2 (2 stall cycles).
  - Faulting access: rsp_valid in cycle 1.
- A req_valid in the RESP cycle is ignored; it belongs to the instruction that is leaving.
- Stores:
  - s_wdata replicates the byte, half or word across all lanes.
  - s_wstrb has size bits set at offset addr[log2(DATA_WIDTH/8)-1:0].
- Loads:
  - Extract the lane at the byte offset.
  - funct3[2]=0 sign-extends; funct3[2]=1 zero-extends to DATA_WIDTH.
  - Stores return rsp_rdata=0.
- Timeout counter: cleared on entry to BUS. When it reaches TIMEOUT_CYCLES it drops s_req, sets cause 3 and goes to RESP.
- reset mid-access: s_req=0 after the edge and no rsp_valid is produced. A late s_ack is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: the timeout counter and cause 3 are present.
- Undefined: no counter; BUS waits indefinitely for s_ack, and cause 3 never occurs.

Decomposition:
- lsu_pkg holds:
  - lsu_state_e {IDLE, BUS, RESP}.
  - fault_cause_e.
  - funct3 constants: LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD.
  - A strobe-generation function.
- Sub-module lsu_load_align: combinational lane extract and sign/zero extend, parametrised by DATA_WIDTH.

Test Plan:
- LW from 0x0000_0010, dmem acks in the first BUS cycle with rdata 0xDEADBEEF -> stall for 2 cycles, rsp_valid in cycle 2, rsp_rdata=0xDEADBEEF.
- LB from 0x0000_0013, rdata 0x80FF_FFFF -> rsp_rdata=0xFFFF_FF80. LBU from the same address -> 0x0000_0080.
- SH to 0x8000_0002 with data 0x1234ABCD, uart acks after 3 cycles -> s_sel=2'b10, s_wstrb=4'b1100, s_wdata=0xABCDABCD, 5 stall cycles.
- LW from 0x0000_0002 -> no s_req, rsp_valid in cycle 1, fault=1, cause=1, fault_addr=0x0000_0002. LW from 0x4000_0000 -> cause 2.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks -> s_req high 4 cycles, then rsp_valid with cause 3. Without the macro -> stall stays high.
- reset asserted in the second BUS cycle -> s_req=0 next cycle, no rsp_valid, state IDLE.
